// File: rtl/booth_mult_datapath_pkg.sv
// rtl/booth_mult_datapath_pkg.sv - shared width, FSM states and Booth action codes
package booth_mult_datapath_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] OP_NONE = 3'd0;
  localparam logic [2:0] OP_ADD1 = 3'd1;
  localparam logic [2:0] OP_ADD2 = 3'd2;
  localparam logic [2:0] OP_SUB1 = 3'd3;
  localparam logic [2:0] OP_SUB2 = 3'd4;

endpackage

// File: rtl/booth_mult_datapath_addend.sv
// rtl/booth_mult_datapath_addend.sv - maps a Booth action code and M to a WIDTH+2 signed addend
module booth_addend
  import booth_mult_datapath_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [2:0]       i_op_code,
  input  logic [WIDTH-1:0] i_m,
  output logic [WIDTH+1:0] o_addend
);

  logic [WIDTH+1:0] w_m1;
  logic [WIDTH+1:0] w_m2;

  assign w_m1 = {{2{i_m[WIDTH-1]}}, i_m};
  assign w_m2 = w_m1 << 1;

  always_comb begin
    o_addend = '0;
    case (i_op_code)
      OP_ADD1: o_addend = w_m1;
      OP_ADD2: o_addend = w_m2;
      OP_SUB1: o_addend = ~w_m1 + 1'b1;
      OP_SUB2: o_addend = ~w_m2 + 1'b1;
      default: o_addend = '0;
    endcase
  end

endmodule

// File: rtl/booth_mult_datapath.sv
// rtl/booth_mult_datapath.sv - radix-4 Booth multiplier datapath: accumulator, multiplier shifter, FSM
module booth_mult_datapath
  import booth_mult_datapath_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [2:0]       booth_bits,
  input  logic [2:0]       op_code,
  output logic             ctrl_en,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY
);

  localparam int AW = WIDTH + 2;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH / 2 - 1);

  state_t           r_state;
  state_t           w_next;
  logic [AW-1:0]    r_a;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_m;
  logic             r_qm1;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_result;
  logic             r_exc;
  logic             r_rdy;
  logic [AW-1:0]    w_addend;
  logic [AW-1:0]    w_sum;
  logic [WIDTH:0]   w_top;
  logic             w_ovf;

  booth_addend #(.WIDTH(WIDTH)) u_addend (
    .i_op_code (op_code),
    .i_m       (r_m),
    .o_addend  (w_addend)
  );

  assign w_sum = r_a + w_addend;
  // The product fits in WIDTH signed bits only if the high word is pure sign extension of Q's MSB.
  assign w_top = {r_a[WIDTH-1:0], r_q[WIDTH-1]};
  assign w_ovf = !((&w_top) || !(|w_top));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (ctrl_MULT) w_next = RUN;
      RUN:     if (!ctrl_MULT && r_count == LAST) w_next = DONE;
      DONE:    w_next = ctrl_MULT ? RUN : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_a      <= '0;
      r_q      <= '0;
      r_m      <= '0;
      r_qm1    <= 1'b0;
      r_count  <= '0;
      r_result <= '0;
      r_exc    <= 1'b0;
      r_rdy    <= 1'b0;
    end else begin
      r_rdy <= 1'b0;
      if (r_state == DONE) begin
        r_rdy    <= 1'b1;
        r_result <= r_q;
        r_exc    <= w_ovf;
      end
      if (ctrl_MULT) begin
        r_m     <= data_operandA;
        r_q     <= data_operandB;
        r_a     <= '0;
        r_qm1   <= 1'b0;
        r_count <= '0;
      end else if (r_state == RUN) begin
        r_a     <= {{2{w_sum[AW-1]}}, w_sum[AW-1:2]};
        r_q     <= {w_sum[1:0], r_q[WIDTH-1:2]};
        r_qm1   <= r_q[1];
        r_count <= r_count + 1'b1;
      end
    end
  end

  assign booth_bits     = {r_q[1], r_q[0], r_qm1};
  assign ctrl_en        = (r_state == RUN);
  assign data_result    = r_result;
  assign data_exception = r_exc;
  assign data_resultRDY = r_rdy;

endmodule

// File: tb/tb_booth_mult_datapath.sv
// tb/tb_booth_mult_datapath.sv - directed bench for booth_mult_datapath with the Booth decoder closing the loop
module tb_booth_mult_datapath;
  import booth_mult_datapath_pkg::*;

  logic        clock;
  logic        reset;
  logic        ctrl_MULT;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [2:0]  booth_bits;
  logic [2:0]  op_code;
  logic        ctrl_en;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;

  int errors = 0;
  int checks = 0;

  booth_mult_datapath #(.WIDTH(32)) dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_MULT      (ctrl_MULT),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .booth_bits     (booth_bits),
    .op_code        (op_code),
    .ctrl_en        (ctrl_en),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always_comb begin
    op_code = OP_NONE;
    case (booth_bits)
      3'b001, 3'b010: op_code = OP_ADD1;
      3'b011:         op_code = OP_ADD2;
      3'b100:         op_code = OP_SUB2;
      3'b101, 3'b110: op_code = OP_SUB1;
      default:        op_code = OP_NONE;
    endcase
  end

  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    ctrl_MULT     = 1'b1;
    data_operandA = a;
    data_operandB = b;
    @(posedge clock); #1;
    ctrl_MULT = 1'b0;
  endtask

  task automatic run_mult(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input logic exp_exc);
    int n;
    n = 0;
    start_op(a, b);
    while (n < 40 && !data_resultRDY) begin
      @(posedge clock); #1;
      n++;
      if (n == 1) begin
        checks++;
        if (ctrl_en !== 1'b1) begin
          errors++; $display("FAIL %s ctrl_en_run: got %b expected 1", name, ctrl_en);
        end
      end
    end
    checks++;
    if (n !== 17) begin
      errors++; $display("FAIL %s latency: got %0d expected 17", name, n);
    end
    checks++;
    if (data_result !== exp_res) begin
      errors++; $display("FAIL %s result: got %h expected %h", name, data_result, exp_res);
    end
    checks++;
    if (data_exception !== exp_exc) begin
      errors++; $display("FAIL %s exception: got %b expected %b", name, data_exception, exp_exc);
    end
    @(posedge clock); #1;
    checks++;
    if (data_resultRDY !== 1'b0 || data_result !== exp_res) begin
      errors++; $display("FAIL %s hold: got rdy=%b res=%h expected rdy=0 res=%h",
                         name, data_resultRDY, data_result, exp_res);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (booth_bits !== 3'b000 || ctrl_en !== 1'b0 || data_result !== 32'h0 ||
        data_exception !== 1'b0 || data_resultRDY !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got bits=%b en=%b res=%h exc=%b rdy=%b expected all 0",
               booth_bits, ctrl_en, data_result, data_exception, data_resultRDY);
    end
  endtask

  task automatic test_products();
    run_mult("3x5",     32'd3,        32'd5,        32'd15,        1'b0);
    run_mult("m7x6",    32'hFFFFFFF9, 32'd6,        32'hFFFFFFD6,  1'b0);
    run_mult("minxm1",  32'h80000000, 32'hFFFFFFFF, 32'h80000000,  1'b1);
    run_mult("2p16sq",  32'h00010000, 32'h00010000, 32'h00000000,  1'b1);
    run_mult("maxsq",   32'h7FFFFFFF, 32'h7FFFFFFF, 32'h00000001,  1'b1);
    run_mult("zero",    32'h00000000, 32'h12345678, 32'h00000000,  1'b0);
  endtask

  task automatic test_restart();
    int pulses;
    int lat;
    pulses = 0;
    lat = -1;
    start_op(32'd9, 32'd9);
    repeat (7) begin
      @(posedge clock); #1;
      if (data_resultRDY) pulses++;
    end
    start_op(32'd4, 32'd4);
    for (int i = 1; i <= 30; i++) begin
      if (i > 1) begin
        @(posedge clock); #1;
      end else begin
        @(posedge clock); #1;
      end
      if (data_resultRDY) begin
        pulses++;
        if (lat < 0) lat = i;
      end
    end
    checks++;
    if (pulses !== 1) begin
      errors++; $display("FAIL restart_pulses: got %0d expected 1", pulses);
    end
    checks++;
    if (lat !== 17) begin
      errors++; $display("FAIL restart_latency: got %0d expected 17", lat);
    end
    checks++;
    if (data_result !== 32'd16) begin
      errors++; $display("FAIL restart_result: got %h expected %h", data_result, 32'd16);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    start_op(32'd3, 32'd5);
    repeat (16) begin
      @(posedge clock); #1;
    end
    ctrl_MULT     = 1'b1;
    data_operandA = 32'd2;
    data_operandB = 32'hFFFFFFFD;
    @(posedge clock); #1;
    ctrl_MULT = 1'b0;
    checks++;
    if (data_resultRDY !== 1'b1 || data_result !== 32'd15) begin
      errors++; $display("FAIL b2b_old: got rdy=%b res=%h expected rdy=1 res=%h",
                         data_resultRDY, data_result, 32'd15);
    end
    checks++;
    if (ctrl_en !== 1'b1) begin
      errors++; $display("FAIL b2b_run: got %b expected 1", ctrl_en);
    end
    n = 0;
    do begin
      @(posedge clock); #1;
      n++;
    end while (n < 40 && !data_resultRDY);
    checks++;
    if (n !== 17 || data_result !== 32'hFFFFFFFA) begin
      errors++; $display("FAIL b2b_new: got lat=%0d res=%h expected lat=17 res=%h",
                         n, data_result, 32'hFFFFFFFA);
    end
  endtask

  task automatic test_reset_midrun();
    int pulses;
    pulses = 0;
    start_op(32'h7FFFFFFF, 32'h7FFFFFFF);
    repeat (5) begin
      @(posedge clock); #1;
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (booth_bits !== 3'b000 || ctrl_en !== 1'b0 || data_result !== 32'h0 ||
        data_exception !== 1'b0 || data_resultRDY !== 1'b0) begin
      errors++;
      $display("FAIL reset_midrun: got bits=%b en=%b res=%h exc=%b rdy=%b expected all 0",
               booth_bits, ctrl_en, data_result, data_exception, data_resultRDY);
    end
    @(posedge clock); #1;
    reset = 1'b0;
    repeat (25) begin
      @(posedge clock); #1;
      if (data_resultRDY) pulses++;
    end
    checks++;
    if (pulses !== 0 || ctrl_en !== 1'b0) begin
      errors++; $display("FAIL reset_norun: got pulses=%0d en=%b expected 0 0", pulses, ctrl_en);
    end
  endtask

  initial begin
    reset         = 1'b1;
    ctrl_MULT     = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    repeat (2) @(posedge clock);
    #1;
    test_reset();
    reset = 1'b0;
    @(posedge clock); #1;
    test_products();
    test_restart();
    test_back_to_back();
    test_reset_midrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
